// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-flow sequencer for the Pong ball engine (attract, serve, play, miss, over)
// Inputs : clk, reset_in (sync, active-high), frame_start (frame tick pulse),
//          start_btn (debounced level), paddle_hit / ball_miss (event pulses)
// Outputs: ball_load (recentre pulse), ball_run (motion enable), ball_speed,
//          score, lives, game_over, win, state (debug code); all registered
module pong_game_ctrl #(
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 90,
    parameter int WIN_SCORE    = 9,
    parameter int LIVES        = 3,
    parameter int SPEEDUP_HITS = 4,
    parameter int MAX_SPEED    = 7
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic       frame_start,
    input  logic       start_btn,
    input  logic       paddle_hit,
    input  logic       ball_miss,
    output logic       ball_load,
    output logic       ball_run,
    output logic [2:0] ball_speed,
    output logic [3:0] score,
    output logic [1:0] lives,
    output logic       game_over,
    output logic       win,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        ATTRACT = 3'd0,
        SERVE   = 3'd1,
        PLAY    = 3'd2,
        MISS    = 3'd3,
        OVER    = 3'd4
    } state_t;

    state_t     state_q;
    logic       start_q;
    logic [7:0] frame_q;
    logic [3:0] hits_q;
    logic       load_q;
    logic       run_q;
    logic [2:0] speed_q;
    logic [3:0] score_q;
    logic [1:0] lives_q;
    logic       over_q;
    logic       win_q;

    logic start_edge;
    assign start_edge = start_btn & ~start_q;

    // ball_run/ball_load/game_over are set on the transition itself so the
    // registered value lines up with the first cycle of the new state.
    always_ff @(posedge clk) begin
        start_q <= start_btn;
        load_q  <= 1'b0;
        if (reset_in) begin
            state_q <= ATTRACT;
            start_q <= 1'b1;
            frame_q <= 8'd0;
            hits_q  <= 4'd0;
            run_q   <= 1'b0;
            speed_q <= 3'd1;
            score_q <= 4'd0;
            lives_q <= 2'(LIVES);
            over_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            case (state_q)
                ATTRACT, OVER: begin
                    if (start_edge) begin
                        state_q <= SERVE;
                        load_q  <= 1'b1;
                        frame_q <= 8'(SERVE_FRAMES);
                        hits_q  <= 4'd0;
                        speed_q <= 3'd1;
                        score_q <= 4'd0;
                        lives_q <= 2'(LIVES);
                        over_q  <= 1'b0;
                        win_q   <= 1'b0;
                    end
                end
                SERVE: begin
                    if (frame_start) begin
                        frame_q <= frame_q - 8'd1;
                        if (frame_q == 8'd1) begin
                            state_q <= PLAY;
                            run_q   <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    // a miss in the same cycle as a hit takes priority
                    if (ball_miss) begin
                        run_q <= 1'b0;
                        if (lives_q == 2'd1) begin
                            state_q <= OVER;
                            lives_q <= 2'd0;
                            win_q   <= 1'b0;
                            over_q  <= 1'b1;
                        end else begin
                            state_q <= MISS;
                            lives_q <= lives_q - 2'd1;
                            frame_q <= 8'(MISS_FRAMES);
                        end
                    end else if (paddle_hit) begin
                        if (score_q + 4'd1 == 4'(WIN_SCORE)) begin
                            state_q <= OVER;
                            score_q <= 4'(WIN_SCORE);
                            win_q   <= 1'b1;
                            over_q  <= 1'b1;
                            run_q   <= 1'b0;
                        end else begin
                            score_q <= score_q + 4'd1;
                        end
                        if (hits_q + 4'd1 == 4'(SPEEDUP_HITS)) begin
                            hits_q  <= 4'd0;
                            speed_q <= (speed_q == 3'(MAX_SPEED)) ? speed_q : speed_q + 3'd1;
                        end else begin
                            hits_q <= hits_q + 4'd1;
                        end
                    end
                end
                MISS: begin
                    if (frame_start) begin
                        frame_q <= frame_q - 8'd1;
                        if (frame_q == 8'd1) begin
                            state_q <= SERVE;
                            load_q  <= 1'b1;
                            frame_q <= 8'(SERVE_FRAMES);
                            speed_q <= 3'd1;
                            hits_q  <= 4'd0;
                        end
                    end
                end
                default: state_q <= ATTRACT;
            endcase
        end
    end

    assign ball_load  = load_q;
    assign ball_run   = run_q;
    assign ball_speed = speed_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign game_over  = over_q;
    assign win        = win_q;
    assign state      = state_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: scoreboard bench for pong_game_ctrl with shortened game parameters
module tb_pong_game_ctrl;
    typedef struct packed {
        logic [2:0] st;
        logic       ld;
        logic       run;
        logic [2:0] spd;
        logic [3:0] sc;
        logic [1:0] lv;
        logic       go;
        logic       wn;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset_in = 1'b1;
    logic       frame_start = 1'b0;
    logic       start_btn = 1'b1;
    logic       paddle_hit = 1'b0;
    logic       ball_miss = 1'b0;
    logic       ball_load;
    logic       ball_run;
    logic [2:0] ball_speed;
    logic [3:0] score;
    logic [1:0] lives;
    logic       game_over;
    logic       win;
    logic [2:0] state;

    int    checks = 0;
    int    failures = 0;
    snap_t e;
    snap_t sb_q[$];

    pong_game_ctrl #(
        .SERVE_FRAMES(3), .MISS_FRAMES(2), .WIN_SCORE(3),
        .LIVES(2), .SPEEDUP_HITS(2), .MAX_SPEED(2)
    ) dut (
        .clk(clk), .reset_in(reset_in), .frame_start(frame_start),
        .start_btn(start_btn), .paddle_hit(paddle_hit), .ball_miss(ball_miss),
        .ball_load(ball_load), .ball_run(ball_run), .ball_speed(ball_speed),
        .score(score), .lives(lives), .game_over(game_over), .win(win),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // drive one cycle of pulses, queue the expected outputs, compare after the edge
    task automatic cyc(input logic fs, input logic ph, input logic bm, input logic rst);
        snap_t x;
        frame_start = fs;
        paddle_hit  = ph;
        ball_miss   = bm;
        reset_in    = rst;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        paddle_hit  = 1'b0;
        ball_miss   = 1'b0;
        reset_in    = 1'b0;
        x = sb_q.pop_front();
        chk("state", int'(state), int'(x.st));
        chk("ball_load", int'(ball_load), int'(x.ld));
        chk("ball_run", int'(ball_run), int'(x.run));
        chk("ball_speed", int'(ball_speed), int'(x.spd));
        chk("score", int'(score), int'(x.sc));
        chk("lives", int'(lives), int'(x.lv));
        chk("game_over", int'(game_over), int'(x.go));
        chk("win", int'(win), int'(x.wn));
    endtask

    // start edge from ATTRACT/OVER: new game, one-cycle ball_load, then idle
    task automatic new_game();
        start_btn = 1'b1;
        e = '{st: 3'd1, ld: 1'b1, run: 1'b0, spd: 3'd1, sc: 4'd0, lv: 2'd2, go: 1'b0, wn: 1'b0};
        cyc(0, 0, 0, 0);
        start_btn = 1'b0;
        e.ld = 1'b0;
        cyc(0, 0, 0, 0);
    endtask

    // three frame ticks, one idle cycle between; PLAY begins right after the third
    task automatic serve_to_play();
        for (int i = 0; i < 3; i++) begin
            e.ld = 1'b0;
            e.st = (i == 2) ? 3'd2 : 3'd1;
            e.run = (i == 2);
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
    endtask

    // two frame ticks in MISS, then back to SERVE with speed reset
    task automatic miss_to_serve();
        e.st = 3'd3;
        cyc(1, 0, 0, 0);
        e.st = 3'd1; e.ld = 1'b1; e.spd = 3'd1;
        cyc(1, 0, 0, 0);
        e.ld = 1'b0;
        cyc(0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset with start held; no auto-start
        e = '{st: 3'd0, ld: 1'b0, run: 1'b0, spd: 3'd1, sc: 4'd0, lv: 2'd2, go: 1'b0, wn: 1'b0};
        cyc(0, 0, 0, 1);
        repeat (10) cyc(0, 0, 0, 0);
        start_btn = 1'b0;
        cyc(0, 0, 0, 0);
        new_game();
        // 2: three frame ticks, spaced 5 cycles
        for (int i = 0; i < 3; i++) begin
            e.st = (i == 2) ? 3'd2 : 3'd1;
            e.run = (i == 2);
            cyc(1, 0, 0, 0);
            repeat (4) cyc(0, 0, 0, 0);
        end
        // 3: two hits speed up; simultaneous hit+miss counts only the miss
        e.sc = 4'd1;
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        e.sc = 4'd2; e.spd = 3'd2;
        cyc(0, 1, 0, 0);
        e.st = 3'd3; e.lv = 2'd1; e.run = 1'b0;
        cyc(0, 1, 1, 0);
        // hits and misses outside PLAY are ignored
        cyc(0, 1, 1, 0);
        // 4: back to serve, then winning hit
        miss_to_serve();
        serve_to_play();
        e.st = 3'd4; e.sc = 4'd3; e.wn = 1'b1; e.go = 1'b1; e.run = 1'b0;
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        // 5: lose both lives
        new_game();
        serve_to_play();
        e.st = 3'd3; e.lv = 2'd1; e.run = 1'b0;
        cyc(0, 0, 1, 0);
        miss_to_serve();
        serve_to_play();
        e.st = 3'd4; e.lv = 2'd0; e.wn = 1'b0; e.go = 1'b1; e.run = 1'b0;
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 1, 0);
        new_game();
        // 6: reset mid-play with score 2, speed 2
        serve_to_play();
        e.sc = 4'd1;
        cyc(0, 1, 0, 0);
        e.sc = 4'd2; e.spd = 3'd2;
        cyc(0, 1, 0, 0);
        e = '{st: 3'd0, ld: 1'b0, run: 1'b0, spd: 3'd1, sc: 4'd0, lv: 2'd2, go: 1'b0, wn: 1'b0};
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        // reset during the serve-load pulse drops it
        start_btn = 1'b1;
        e = '{st: 3'd1, ld: 1'b1, run: 1'b0, spd: 3'd1, sc: 4'd0, lv: 2'd2, go: 1'b0, wn: 1'b0};
        cyc(0, 0, 0, 0);
        e = '{st: 3'd0, ld: 1'b0, run: 1'b0, spd: 3'd1, sc: 4'd0, lv: 2'd2, go: 1'b0, wn: 1'b0};
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-flow sequencer for the Pong datapath. It decides when the ball engine is held, recentred or running. It consumes the per-frame tick plus paddle-hit and ball-miss event pulses from the ball/paddle logic. It drives the serve countdown, score, lives, ball speed and game-over status used by display_pong and its renderer.

Parameters:
SERVE_FRAMES, 60, frames the ball stays parked before each serve (1..255)
MISS_FRAMES, 90, frames of pause after a miss before the next serve (1..255)
WIN_SCORE, 9, score that ends the game with a win (1..15)
LIVES, 3, lives at game start (1..3)
SPEEDUP_HITS, 4, paddle hits per speed increment (1..15)
MAX_SPEED, 7, ball speed ceiling (1..7)

Ports:
clk  in  1  system clock (single clock domain)
reset_in  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse per video frame
start_btn  in  1  start button level, already debounced
paddle_hit  in  1  one-cycle pulse: ball bounced off paddle
ball_miss  in  1  one-cycle pulse: ball passed paddle
ball_load  out  1  one-cycle pulse: recentre ball, reload direction
ball_run  out  1  ball motion enable (level)
ball_speed  out  3  pixels per frame for ball motion
score  out  4  current score
lives  out  2  remaining lives
game_over  out  1  high in OVER state
win  out  1  high in OVER when the game ended on WIN_SCORE
state  out  3  FSM state code, for debug export

Behaviour:
- All outputs are registered. Single clock domain: clk. Reset is synchronous and active-high on reset_in.
- Reset values: state=ATTRACT(0), ball_load=0, ball_run=0, ball_speed=1, score=0, lives=LIVES, game_over=0, win=0. Internal: frame counter=0, hit counter=0, start_q=1.
- start_q resets to 1, so a button held through reset does not auto-start.
- Start edge: start_btn=1 and start_q=0. start_q follows start_btn every cycle.
- State codes: ATTRACT=0, SERVE=1, PLAY=2, MISS=3, OVER=4.
- ATTRACT:
  - ball_run=0.
  - On a start edge, go to SERVE and start a new game: score=0, lives=LIVES, speed=1, hit counter=0, win=0, frame counter=SERVE_FRAMES.
  - A frame_start in the same cycle as the start edge is not counted.
- SERVE:
  - ball_run=0.
  - ball_load is high for exactly the first cycle the state register holds SERVE, on every entry.
  - Each frame_start decrements the frame counter.
  - A frame_start with counter==1 goes to PLAY, so exactly SERVE_FRAMES ticks are spent in SERVE.
- PLAY:
  - ball_run=1 for every cycle state==PLAY.
  - paddle_hit: if score+1==WIN_SCORE, go to OVER with score=WIN_SCORE and win=1. Otherwise increment score.
  - paddle_hit also increments the hit counter. When it reaches SPEEDUP_HITS, clear it and increment ball_speed, saturating at MAX_SPEED.
  - ball_miss: if lives==1, go to OVER with lives=0 and win=0. Otherwise decrement lives and go to MISS with frame counter=MISS_FRAMES.
  - paddle_hit and ball_miss in the same cycle: the miss wins and the hit is discarded.
- MISS:
  - ball_run=0.
  - Each frame_start decrements the counter.
  - A frame_start with counter==1 goes to SERVE with counter=SERVE_FRAMES, ball_speed=1, hit counter=0. Score and lives are kept.
- OVER:
  - game_over=1, ball_run=0.
  - score, lives and win are held.
  - On a start edge, start a new game exactly as from ATTRACT.
- Ignored inputs:
  - paddle_hit and ball_miss outside PLAY.
  - Start edges in SERVE, PLAY and MISS.
- ball_run drops in the same cycle the state leaves PLAY; the first registered cycle in MISS or OVER shows 0.
- Reset mid-game: the cycle after reset_in is sampled high, all outputs are at their reset values. No pending ball_load pulse survives reset.
- Arithmetic:
  - 8-bit frame counter.
  - Score and lives never wrap: saturating or guarded as above.
  - Out-of-range parameters are not supported.

Test Plan:
The bench uses SERVE_FRAMES=3, MISS_FRAMES=2, WIN_SCORE=3, LIVES=2, SPEEDUP_HITS=2, MAX_SPEED=2.

1. Reset with start_btn held high, keep high 10 cycles -> state stays 0, ball_run=0. Release, then pulse high -> state=1, ball_load high exactly 1 cycle, lives=2, score=0.
2. In SERVE, give 3 frame_start pulses spaced 5 cycles apart -> state=2 and ball_run=1 right after the 3rd pulse; state=1 until then.
3. In PLAY, send 2 paddle_hit pulses -> score=2, ball_speed=2. Then assert paddle_hit and ball_miss in the same cycle -> score stays 2, lives=1, state=3, ball_run=0.
4. In MISS, give 2 frame_start pulses -> state=1, ball_load 1 cycle, ball_speed=1, score=2. After 3 more frames, one paddle_hit -> state=4, win=1, game_over=1, score=3.
5. Repeat a game to lives=1, then ball_miss -> state=4, lives=0, win=0. A paddle_hit in OVER leaves score unchanged. A start edge -> state=1, score=0, lives=2.
6. Assert reset_in for 1 cycle while in PLAY with score=2, speed=2 -> next cycle state=0, score=0, lives=2, ball_speed=1, ball_run=0, ball_load=0.
